m68k_bus_target: RTL and testbench

M68K_BUS_TARGET -- requirements
Module: m68k_bus_target

---
 rtl/m68k_bus_target.sv | 172 +++++++++++++++++
 tb/tb_m68k_bus_target.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_target.sv
// MC68000 bus target: eight 16-bit registers in a 16-byte window, with DTACK wait states.
// Optional BERR watchdog on unacknowledged strobes is built when WDOG_BERR_EN is defined.
module m68k_bus_target #(
  parameter logic [22:0] BASE_ADDR   = 23'h7F_FFF0,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [15:0] ID_VALUE    = 16'hA55A,
  parameter int unsigned WDOG_LIMIT  = 64
) (
  input  logic        M68K_CLK,
  input  logic        M68K_RESET_n,
  input  logic [22:0] M68K_A,
  input  logic [2:0]  M68K_FC,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  output logic        M68K_DTACK_n,
  input  logic        M68K_DTACK_IN_n,
  output logic        M68K_BERR_n
);

  typedef enum logic [2:0] {StIdle, StWait, StAck, StRelease, StSkip} state_e;

  // BASE_ADDR is a byte address; bit 23 of the window is taken as zero.
  localparam logic [23:0] BaseByte = {1'b0, BASE_ADDR};
  localparam logic [3:0]  WaitLast = 4'(WAIT_STATES);

  logic [3:0]  sync1_q, sync2_q;
  logic        as_s, uds_s, lds_s, dtin_s;
  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        dtack_q, dtack_d;
  logic        oe_q, oe_d;
  logic [15:0] dout_q, dout_d;
  logic [2:0]  sel_q;
  logic        rw_q, uds_q, lds_q;
  logic        capture, wr_en, hit;
  logic [15:0] rd_data;
  logic [15:0] regs_q [8];

  assign {as_s, uds_s, lds_s, dtin_s} = sync2_q;

  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= {M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_DTACK_IN_n};
      sync2_q <= sync1_q;
    end
  end

  // M68K_A[22:3] is A[23:4]; M68K_A[2:0] is A[3:1], the register select.
  assign hit     = (M68K_A[22:3] == BaseByte[23:4]) && (M68K_FC != 3'b111);
  assign rd_data = (M68K_A[2:0] == 3'd7) ? ID_VALUE : regs_q[M68K_A[2:0]];

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    dtack_d = dtack_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    capture = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!as_s && (!uds_s || !lds_s)) begin
          capture = 1'b1;
          wcnt_d  = '0;
          if (hit) begin
            state_d = StWait;
            if (M68K_RW) begin
              dout_d = rd_data;
              oe_d   = 1'b1;
            end
          end else begin
            state_d = StSkip;
          end
        end
      end
      StWait: begin
        if (as_s) begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end else if (wcnt_q == WaitLast) begin
          state_d = StAck;
          dtack_d = 1'b0;
          wr_en   = !rw_q;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      StAck: begin
        if (as_s) begin
          state_d = StRelease;
          dtack_d = 1'b1;
          oe_d    = 1'b0;
        end
      end
      StRelease: state_d = StIdle;
      StSkip:    if (as_s) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      dtack_q <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      sel_q   <= '0;
      rw_q    <= 1'b1;
      uds_q   <= 1'b1;
      lds_q   <= 1'b1;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      dtack_q <= dtack_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      if (capture) begin
        sel_q <= M68K_A[2:0];
        rw_q  <= M68K_RW;
        uds_q <= uds_s;
        lds_q <= lds_s;
      end
      // Register 7 is the read-only ID and never takes a write.
      if (wr_en && (sel_q != 3'd7)) begin
        if (!uds_q) regs_q[sel_q][15:8] <= M68K_D_IN[15:8];
        if (!lds_q) regs_q[sel_q][7:0]  <= M68K_D_IN[7:0];
      end
    end
  end

  assign M68K_D_OUT   = dout_q;
  assign M68K_D_OE    = oe_q;
  assign M68K_DTACK_n = dtack_q;

`ifdef WDOG_BERR_EN
  localparam logic [15:0] Limit = 16'(WDOG_LIMIT);

  logic [15:0] wdog_q;
  logic        berr_q;

  // Counts only while nobody on the bus has acknowledged; saturates at the limit.
  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      wdog_q <= '0;
      berr_q <= 1'b1;
    end else if (as_s) begin
      wdog_q <= '0;
      berr_q <= 1'b1;
    end else if (dtin_s && dtack_q && (wdog_q != Limit)) begin
      wdog_q <= wdog_q + 16'd1;
      if ((wdog_q + 16'd1) == Limit) berr_q <= 1'b0;
    end
  end

  assign M68K_BERR_n = berr_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^{dtin_s, WDOG_LIMIT[0]};
  assign M68K_BERR_n = 1'b1;
`endif

endmodule

// File: tb/tb_m68k_bus_target.sv
// Bench for m68k_bus_target: three instances (0, 3 and 8 wait states) share one bus and are
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_m68k_bus_target;

  localparam logic [23:0] BASE  = 24'h7F_FFF0;
  localparam logic [15:0] ID    = 16'hA55A;
  localparam int          NI    = 3;
  localparam int          LIMIT = 64;

  logic        clk;
  logic        rst_n;
  logic [22:0] a;
  logic [2:0]  fc;
  logic        as_n, uds_n, lds_n, rw;
  logic [15:0] d_in;
  logic        dtack_in_n;
  logic [15:0] d_out   [NI];
  logic        d_oe    [NI];
  logic        dtack_n [NI];
  logic        berr_n  [NI];

  int n_checks = 0;
  int n_err    = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    m68k_bus_target #(
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : 8)
    ) u_dut (
      .M68K_CLK       (clk),
      .M68K_RESET_n   (rst_n),
      .M68K_A         (a),
      .M68K_FC        (fc),
      .M68K_AS_n      (as_n),
      .M68K_UDS_n     (uds_n),
      .M68K_LDS_n     (lds_n),
      .M68K_RW        (rw),
      .M68K_D_IN      (d_in),
      .M68K_D_OUT     (d_out[g]),
      .M68K_D_OE      (d_oe[g]),
      .M68K_DTACK_n   (dtack_n[g]),
      .M68K_DTACK_IN_n(dtack_in_n),
      .M68K_BERR_n    (berr_n[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %h, expected %h (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_st: 0 idle, 1 pending acknowledge, 2 ignoring (miss), 3 one release clock, 4 acknowledged
  int          cyc;
  int          m_st   [NI];
  int          m_tack [NI];
  int          m_sel  [NI];
  logic        m_rw   [NI], m_u [NI], m_l [NI];
  logic        e_dtack[NI], e_oe [NI], e_berr [NI];
  logic [15:0] e_dout [NI];
  logic [15:0] m_reg  [NI][8];
  logic        p_as, p_u, p_l, s_as, s_u, s_l;
`ifdef WDOG_BERR_EN
  logic        p_dt, s_dt;
  int          m_wd [NI];
`endif

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 3 : 8;
  endfunction

  task automatic m_reset();
    cyc = 0;
    {p_as, p_u, p_l, s_as, s_u, s_l} = '1;
`ifdef WDOG_BERR_EN
    p_dt = 1'b1; s_dt = 1'b1;
`endif
    for (int i = 0; i < NI; i++) begin
      m_st[i] = 0; e_dtack[i] = 1'b1; e_oe[i] = 1'b0; e_berr[i] = 1'b1; e_dout[i] = '0;
      for (int r = 0; r < 8; r++) m_reg[i][r] = '0;
`ifdef WDOG_BERR_EN
      m_wd[i] = 0;
`endif
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
`ifdef WDOG_BERR_EN
          if (s_as) begin
            m_wd[i] = 0; e_berr[i] = 1'b1;
          end else if (s_dt && e_dtack[i] && m_wd[i] < LIMIT) begin
            m_wd[i]++;
            if (m_wd[i] == LIMIT) e_berr[i] = 1'b0;
          end
`endif
          if (m_st[i] == 3) m_st[i] = 0;
          else if (m_st[i] == 0) begin
            if (!s_as && (!s_u || !s_l)) begin
              m_sel[i] = int'(a[2:0]); m_rw[i] = rw; m_u[i] = s_u; m_l[i] = s_l;
              if ((({a, 1'b0} & 24'hFF_FFF0) == BASE) && fc != 3'd7) begin
                m_st[i] = 1; m_tack[i] = cyc + ws_of(i) + 1;
                if (rw) begin
                  e_dout[i] = (m_sel[i] == 7) ? ID : m_reg[i][m_sel[i]];
                  e_oe[i]   = 1'b1;
                end
              end else m_st[i] = 2;
            end
          end else if (m_st[i] == 2) begin
            if (s_as) m_st[i] = 0;
          end else if (m_st[i] == 1) begin
            if (s_as) begin
              m_st[i] = 0; e_oe[i] = 1'b0;
            end else if (cyc == m_tack[i]) begin
              m_st[i] = 4; e_dtack[i] = 1'b0;
              if (!m_rw[i] && m_sel[i] != 7) begin
                if (!m_u[i]) m_reg[i][m_sel[i]][15:8] = d_in[15:8];
                if (!m_l[i]) m_reg[i][m_sel[i]][7:0]  = d_in[7:0];
              end
            end
          end else if (m_st[i] == 4 && s_as) begin
            m_st[i] = 3; e_dtack[i] = 1'b1; e_oe[i] = 1'b0;
          end
        end
        {s_as, s_u, s_l} = {p_as, p_u, p_l};
        {p_as, p_u, p_l} = {as_n, uds_n, lds_n};
`ifdef WDOG_BERR_EN
        s_dt = p_dt; p_dt = dtack_in_n;
`endif
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk("dtack_n", i, 16'(dtack_n[i]), 16'(e_dtack[i]));
        chk("d_oe", i, 16'(d_oe[i]), 16'(e_oe[i]));
        if (e_oe[i]) chk("d_out", i, d_out[i], e_dout[i]);
        chk("berr_n", i, 16'(berr_n[i]), 16'(e_berr[i]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int          first_dtack [NI];
  int          first_oe    [NI];
  int          first_berr  [NI];
  logic [15:0] ack_data    [NI];

  // Counts posedges after driving the strobes; edge N is count 3 (two-flop sync).
  task automatic bus_cycle(input logic [23:0] baddr, input logic [2:0] f, input logic r,
                           input logic u, input logic l, input logic [15:0] d, input int hold);
    @(negedge clk);
    a = baddr[23:1]; fc = f; rw = r; d_in = d; uds_n = u; lds_n = l; as_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      first_dtack[i] = 0; first_oe[i] = 0; first_berr[i] = 0; ack_data[i] = '0;
    end
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (!dtack_n[i] && first_dtack[i] == 0) begin
          first_dtack[i] = k; ack_data[i] = d_out[i];
        end
        if (d_oe[i] && first_oe[i] == 0) first_oe[i] = k;
        if (!berr_n[i] && first_berr[i] == 0) first_berr[i] = k;
      end
    end
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  int got;

  initial begin
    rst_n = 1'b0; a = '0; fc = 3'd5; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    d_in = '0; dtack_in_n = 1'b1;
    #12;
    chk("rst_dtack", 0, 16'(dtack_n[0]), 16'h1);
    chk("rst_oe", 0, 16'(d_oe[0]), 16'h0);
    chk("rst_dout", 0, d_out[0], 16'h0000);
    chk("rst_berr", 0, 16'(berr_n[0]), 16'h1);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full write to register 1, then read it back.
    bus_cycle(BASE + 24'd2, 3'd5, 1'b0, 1'b0, 1'b0, 16'h1234, 14);
    chk("wr_lat_ws0", 0, 16'(first_dtack[0]), 16'd4);
    chk("wr_lat_ws3", 1, 16'(first_dtack[1]), 16'd7);
    chk("wr_lat_ws8", 2, 16'(first_dtack[2]), 16'd12);
    bus_cycle(BASE + 24'd2, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0, 14);
    chk("rd_reg1", 0, ack_data[0], 16'h1234);
    chk("rd_oe_edge", 0, 16'(first_oe[0]), 16'd3);

    // Low-byte write, then read.
    bus_cycle(BASE + 24'd2, 3'd5, 1'b0, 1'b1, 1'b0, 16'hFF77, 14);
    bus_cycle(BASE + 24'd2, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0, 14);
    chk("byte_wr", 0, ack_data[0], 16'h1277);
    chk("byte_wr", 1, ack_data[1], 16'h1277);
    chk("oe_before_ack", 0, 16'(first_dtack[0] - first_oe[0]), 16'd1);

    // ID register: read, attempted write, read again.
    bus_cycle(BASE + 24'd14, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0, 14);
    chk("id_rd", 1, ack_data[1], 16'hA55A);
    chk("id_lat_ws3", 1, 16'(first_dtack[1]), 16'd7);
    bus_cycle(BASE + 24'd14, 3'd5, 1'b0, 1'b0, 1'b0, 16'h0000, 14);
    bus_cycle(BASE + 24'd14, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0, 14);
    chk("id_rd_after_wr", 1, ack_data[1], 16'hA55A);

    // Miss above the window, CPU space at the base, and a read with no data strobes.
    bus_cycle(BASE + 24'd16, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0, 14);
    chk("miss_dtack", 0, 16'(first_dtack[0]), 16'd0);
    chk("miss_oe", 0, 16'(first_oe[0]), 16'd0);
    bus_cycle(BASE, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0, 14);
    chk("cpu_dtack", 2, 16'(first_dtack[2]), 16'd0);
    chk("cpu_oe", 2, 16'(first_oe[2]), 16'd0);
    bus_cycle(BASE, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, 14);
    chk("nostrobe_oe", 0, 16'(first_oe[0]), 16'd0);

    // AS released two clocks after edge N: the 8-wait-state target must abort.
    bus_cycle(BASE + 24'd4, 3'd5, 1'b0, 1'b0, 1'b0, 16'hBEEF, 5);
    chk("abort_dtack", 2, 16'(first_dtack[2]), 16'd0);
    chk("abort_other", 0, 16'(first_dtack[0]), 16'd4);
    bus_cycle(BASE + 24'd4, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0, 14);
    chk("abort_nowr", 2, ack_data[2], 16'h0000);
    chk("abort_wr_ok", 0, ack_data[0], 16'hBEEF);

    // Reset while instance 0 is acknowledging a read.
    @(negedge clk);
    a = BASE[23:1] + 23'd1; fc = 3'd5; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      @(posedge clk);
      #1;
      if (!dtack_n[0]) got = 1;
    end
    chk("ack_before_rst", 0, 16'(got), 16'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_mid_dtack", i, 16'(dtack_n[i]), 16'h1);
      chk("rst_mid_oe", i, 16'(d_oe[i]), 16'h0);
    end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_cycle(BASE + 24'd2, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0, 14);
    chk("rd_after_rst", 0, ack_data[0], 16'h0000);

    // Long unacknowledged strobe to a miss address.
    bus_cycle(BASE + 24'd32, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0, 100);
`ifdef WDOG_BERR_EN
    chk("wdog_berr_at", 0, 16'(first_berr[0]), 16'd66);
`else
    chk("wdog_none", 0, 16'(first_berr[0]), 16'd0);
`endif
    chk("berr_after", 0, 16'(berr_n[0]), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
